// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and helpers for the FFT frame sequencer: FSM states, RAM owner
// select and the power-of-two frame length check.
package fft_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_LOAD,
        SEQ_STAGE_START,
        SEQ_STAGE_RUN,
        SEQ_DONE,
        SEQ_ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_BRIDGE,
        OWN_CORE
    } ram_owner_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] log2;
    } pow2_t;

    // valid only for an exact power of two in [2, 2**max_log2]
    function automatic pow2_t f_pow2_log2(input logic [11:0] n, input int max_log2);
        pow2_t r;
        r = '0;
        for (int i = 1; i < 12; i++) begin
            if (n == 12'(1 << i) && i <= max_log2) begin
                r.valid = 1'b1;
                r.log2  = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Bridge/core/RAM signal bundle of the frame sequencer. The master side is the
// environment (bridge, core, RAM); the slave side is the sequencer itself.
interface fft_frame_sequencer_if #(parameter int DATA_WIDTH = 32);
    logic                  i_DATA_LOADED;
    logic [11:0]           i_SAMPLES_NUMBER;
    logic                  i_RESULT_READ;
    logic                  i_CLEAR;
    logic                  i_BR_WRITE;
    logic                  i_BR_READ;
    logic [11:0]           i_BR_INDEX;
    logic [15:0]           i_BR_SAMPLE;
    logic                  i_CORE_WE;
    logic                  i_CORE_RE;
    logic [11:0]           i_CORE_ADDR;
    logic [DATA_WIDTH-1:0] i_CORE_WDATA;
    logic                  i_STAGE_DONE;
    logic [DATA_WIDTH-1:0] i_RAM_RDATA;
    logic                  o_RAM_WE;
    logic                  o_RAM_RE;
    logic [11:0]           o_RAM_ADDR;
    logic [DATA_WIDTH-1:0] o_RAM_WDATA;
    logic [DATA_WIDTH-1:0] o_BR_RDATA;
    logic [DATA_WIDTH-1:0] o_CORE_RDATA;
    logic                  o_BR_BLOCKED;
    logic                  o_STAGE_START;
    logic [3:0]            o_STAGE;
    logic                  o_CALC_END;
    logic                  o_ERROR;

    modport master (
        output i_DATA_LOADED, i_SAMPLES_NUMBER, i_RESULT_READ, i_CLEAR,
               i_BR_WRITE, i_BR_READ, i_BR_INDEX, i_BR_SAMPLE,
               i_CORE_WE, i_CORE_RE, i_CORE_ADDR, i_CORE_WDATA,
               i_STAGE_DONE, i_RAM_RDATA,
        input  o_RAM_WE, o_RAM_RE, o_RAM_ADDR, o_RAM_WDATA, o_BR_RDATA,
               o_CORE_RDATA, o_BR_BLOCKED, o_STAGE_START, o_STAGE,
               o_CALC_END, o_ERROR
    );

    modport slave (
        input  i_DATA_LOADED, i_SAMPLES_NUMBER, i_RESULT_READ, i_CLEAR,
               i_BR_WRITE, i_BR_READ, i_BR_INDEX, i_BR_SAMPLE,
               i_CORE_WE, i_CORE_RE, i_CORE_ADDR, i_CORE_WDATA,
               i_STAGE_DONE, i_RAM_RDATA,
        output o_RAM_WE, o_RAM_RE, o_RAM_ADDR, o_RAM_WDATA, o_BR_RDATA,
               o_CORE_RDATA, o_BR_BLOCKED, o_STAGE_START, o_STAGE,
               o_CALC_END, o_ERROR
    );
endinterface

// File: rtl/fft_ram_mux.sv
// Combinational single-port RAM arbiter: passes the current owner's strobes,
// address and data through and drops everything from the other side.
module fft_ram_mux
    import fft_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  ram_owner_t            owner,
    input  logic                  br_write,
    input  logic                  br_read,
    input  logic [11:0]           br_index,
    input  logic [15:0]           br_sample,
    input  logic                  core_we,
    input  logic                  core_re,
    input  logic [11:0]           core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [11:0]           ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  br_blocked
);

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (owner)
            OWN_BRIDGE: begin
                ram_we    = br_write;
                ram_re    = br_read;
                ram_addr  = br_index;
                ram_wdata = {{(DATA_WIDTH-16){1'b0}}, br_sample};
            end
            OWN_CORE: begin
                ram_we    = core_we;
                ram_re    = core_re;
                ram_addr  = core_addr;
                ram_wdata = core_wdata;
            end
            default: ;
        endcase
        br_blocked = (br_write || br_read) && (owner != OWN_BRIDGE);
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// FFT frame controller: load -> log2(N) stages -> readout, with RAM ownership
// arbitration and a per-stage watchdog.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_LOG2       = 11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fft_frame_sequencer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t    state, state_nx;
    logic [3:0]    stage, stage_nx;
    logic [3:0]    num_stages, num_stages_nx;
    logic [TW-1:0] timer, timer_nx;
    ram_owner_t    owner;
    pow2_t         chk;

    assign chk = f_pow2_log2(bus.i_SAMPLES_NUMBER, MAX_LOG2);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= SEQ_LOAD;
            stage      <= '0;
            num_stages <= '0;
            timer      <= '0;
        end else begin
            state      <= state_nx;
            stage      <= stage_nx;
            num_stages <= num_stages_nx;
            timer      <= timer_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        stage_nx      = stage;
        num_stages_nx = num_stages;
        timer_nx      = timer;
        owner         = OWN_NONE;
        case (state)
            SEQ_LOAD: begin
                owner = OWN_BRIDGE;
                if (bus.i_DATA_LOADED) begin
                    if (chk.valid) begin
                        num_stages_nx = chk.log2;
                        stage_nx      = '0;
                        state_nx      = SEQ_STAGE_START;
                    end else begin
                        state_nx = SEQ_ERROR;
                    end
                end
            end
            SEQ_STAGE_START: begin
                owner    = OWN_CORE;
                timer_nx = '0;
                state_nx = SEQ_STAGE_RUN;
            end
            SEQ_STAGE_RUN: begin
                owner    = OWN_CORE;
                timer_nx = timer + 1'b1;
                // a done on the watchdog's last cycle still counts
                if (bus.i_STAGE_DONE) begin
                    if (stage == num_stages - 4'd1) begin
                        state_nx = SEQ_DONE;
                    end else begin
                        stage_nx = stage + 4'd1;
                        state_nx = SEQ_STAGE_START;
                    end
                end else if (timer == TIMER_LAST) begin
                    state_nx = SEQ_ERROR;
                end
            end
            SEQ_DONE: begin
                owner = OWN_BRIDGE;
                if (bus.i_RESULT_READ) state_nx = SEQ_LOAD;
            end
            SEQ_ERROR: begin
                if (bus.i_CLEAR) state_nx = SEQ_LOAD;
            end
            default: state_nx = SEQ_LOAD;
        endcase
    end

    always_comb begin
        bus.o_STAGE_START = (state == SEQ_STAGE_START);
        bus.o_CALC_END    = (state == SEQ_DONE);
        bus.o_ERROR       = (state == SEQ_ERROR);
        bus.o_STAGE       = stage;
        bus.o_BR_RDATA    = bus.i_RAM_RDATA;
        bus.o_CORE_RDATA  = bus.i_RAM_RDATA;
    end

    fft_ram_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
        .owner      (owner),
        .br_write   (bus.i_BR_WRITE),
        .br_read    (bus.i_BR_READ),
        .br_index   (bus.i_BR_INDEX),
        .br_sample  (bus.i_BR_SAMPLE),
        .core_we    (bus.i_CORE_WE),
        .core_re    (bus.i_CORE_RE),
        .core_addr  (bus.i_CORE_ADDR),
        .core_wdata (bus.i_CORE_WDATA),
        .ram_we     (bus.o_RAM_WE),
        .ram_re     (bus.o_RAM_RE),
        .ram_addr   (bus.o_RAM_ADDR),
        .ram_wdata  (bus.o_RAM_WDATA),
        .br_blocked (bus.o_BR_BLOCKED)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: frame flow, bad N, watchdog, RAM
// arbitration, mid-frame reset and back-to-back frames.
module tb_fft_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.DATA_WIDTH(32)) bus ();

    fft_frame_sequencer #(
        .DATA_WIDTH(32), .MAX_LOG2(11), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_DATA_LOADED = 0; bus.i_SAMPLES_NUMBER = '0; bus.i_RESULT_READ = 0;
        bus.i_CLEAR = 0; bus.i_BR_WRITE = 0; bus.i_BR_READ = 0; bus.i_BR_INDEX = '0;
        bus.i_BR_SAMPLE = '0; bus.i_CORE_WE = 0; bus.i_CORE_RE = 0; bus.i_CORE_ADDR = '0;
        bus.i_CORE_WDATA = '0; bus.i_STAGE_DONE = 0; bus.i_RAM_RDATA = '0;
    endtask

    task automatic load_frame(input logic [11:0] n);
        bus.i_SAMPLES_NUMBER = n;
        bus.i_DATA_LOADED = 1;
        tick();
        bus.i_DATA_LOADED = 0;
    endtask

    // Runs a full frame of n samples; core answers done 5 cycles after each pulse.
    task automatic run_frame(input logic [11:0] n, input int stages);
        load_frame(n);
        for (int s = 0; s < stages; s++) begin
            checks++; if (bus.o_STAGE_START !== 1'b1) begin failures++; $display("FAIL frame%0d_pulse s=%0d got=%b exp=1", n, s, bus.o_STAGE_START); end
            checks++; if (bus.o_STAGE !== 4'(s)) begin failures++; $display("FAIL frame%0d_stage got=%0d exp=%0d", n, bus.o_STAGE, s); end
            tick();
            checks++; if (bus.o_STAGE_START !== 1'b0) begin failures++; $display("FAIL frame%0d_pulse_width s=%0d got=%b exp=0", n, s, bus.o_STAGE_START); end
            repeat (4) tick();
            bus.i_STAGE_DONE = 1;
            tick();
            bus.i_STAGE_DONE = 0;
        end
        checks++; if (bus.o_CALC_END !== 1'b1) begin failures++; $display("FAIL frame%0d_calc_end got=%b exp=1", n, bus.o_CALC_END); end
        tick();
        checks++; if (bus.o_CALC_END !== 1'b1 || bus.o_STAGE_START !== 1'b0) begin failures++; $display("FAIL frame%0d_calc_end_hold got=%b/%b exp=1/0", n, bus.o_CALC_END, bus.o_STAGE_START); end
        bus.i_RESULT_READ = 1;
        tick();
        bus.i_RESULT_READ = 0;
        checks++; if (bus.o_CALC_END !== 1'b0) begin failures++; $display("FAIL frame%0d_read_back got=%b exp=0", n, bus.o_CALC_END); end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) tick();
        rst = 0;
        checks++; if ({bus.o_STAGE_START, bus.o_STAGE, bus.o_CALC_END, bus.o_ERROR} !== 7'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=0", {bus.o_STAGE_START, bus.o_STAGE, bus.o_CALC_END, bus.o_ERROR}); end
        bus.i_STAGE_DONE = 1;
        tick();
        bus.i_STAGE_DONE = 0;
        checks++; if (bus.o_STAGE_START !== 1'b0 || bus.o_CALC_END !== 1'b0) begin failures++; $display("FAIL load_ignores_done got=%b/%b exp=0/0", bus.o_STAGE_START, bus.o_CALC_END); end
    endtask

    task automatic test_frame_n8();
        run_frame(12'd8, 3);
    endtask

    task automatic test_bad_n(input logic [11:0] n);
        load_frame(n);
        checks++; if (bus.o_ERROR !== 1'b1 || bus.o_STAGE_START !== 1'b0) begin failures++; $display("FAIL bad_n%0d got err=%b pulse=%b exp err=1 pulse=0", n, bus.o_ERROR, bus.o_STAGE_START); end
        load_frame(12'd4);
        checks++; if (bus.o_ERROR !== 1'b1 || bus.o_STAGE_START !== 1'b0) begin failures++; $display("FAIL error_ignores_load got err=%b pulse=%b exp err=1 pulse=0", bus.o_ERROR, bus.o_STAGE_START); end
        bus.i_CLEAR = 1;
        tick();
        bus.i_CLEAR = 0;
        checks++; if (bus.o_ERROR !== 1'b0) begin failures++; $display("FAIL clear got=%b exp=0", bus.o_ERROR); end
        run_frame(12'd4, 2);
    endtask

    task automatic test_timeout();
        load_frame(12'd8);
        checks++; if (bus.o_STAGE_START !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", bus.o_STAGE_START); end
        repeat (16) tick();
        checks++; if (bus.o_ERROR !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0 at +16", bus.o_ERROR); end
        tick();
        checks++; if (bus.o_ERROR !== 1'b1) begin failures++; $display("FAIL to_fire got=%b exp=1 at +17", bus.o_ERROR); end
        bus.i_CLEAR = 1;
        tick();
        bus.i_CLEAR = 0;
        // done on the watchdog's final cycle wins
        load_frame(12'd2);
        repeat (16) tick();
        bus.i_STAGE_DONE = 1;
        tick();
        bus.i_STAGE_DONE = 0;
        checks++; if (bus.o_ERROR !== 1'b0 || bus.o_CALC_END !== 1'b1) begin failures++; $display("FAIL to_done_wins got err=%b end=%b exp err=0 end=1", bus.o_ERROR, bus.o_CALC_END); end
        bus.i_RESULT_READ = 1;
        tick();
        bus.i_RESULT_READ = 0;
    endtask

    task automatic test_mux_and_reset();
        load_frame(12'd8);
        tick();
        bus.i_BR_WRITE = 1; bus.i_BR_INDEX = 12'h005; bus.i_BR_SAMPLE = 16'hBEEF;
        bus.i_CORE_WE = 1; bus.i_CORE_ADDR = 12'h00A; bus.i_CORE_WDATA = 32'h1234_5678;
        bus.i_RAM_RDATA = 32'hCAFE_F00D;
        #1;
        checks++; if (bus.o_RAM_ADDR !== 12'h00A || bus.o_RAM_WE !== 1'b1) begin failures++; $display("FAIL mux_core_addr got=%h we=%b exp=00a we=1", bus.o_RAM_ADDR, bus.o_RAM_WE); end
        checks++; if (bus.o_RAM_WDATA !== 32'h1234_5678) begin failures++; $display("FAIL mux_core_data got=%h exp=12345678", bus.o_RAM_WDATA); end
        checks++; if (bus.o_BR_BLOCKED !== 1'b1) begin failures++; $display("FAIL mux_blocked got=%b exp=1", bus.o_BR_BLOCKED); end
        checks++; if (bus.o_BR_RDATA !== 32'hCAFE_F00D || bus.o_CORE_RDATA !== 32'hCAFE_F00D) begin failures++; $display("FAIL rdata got=%h/%h exp=cafef00d", bus.o_BR_RDATA, bus.o_CORE_RDATA); end
        bus.i_BR_WRITE = 0; bus.i_CORE_WE = 0;
        repeat (3) tick();
        bus.i_STAGE_DONE = 1;
        tick();
        bus.i_STAGE_DONE = 0;
        checks++; if (bus.o_STAGE !== 4'd1 || bus.o_STAGE_START !== 1'b1) begin failures++; $display("FAIL mux_stage1 got=%0d/%b exp=1/1", bus.o_STAGE, bus.o_STAGE_START); end
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        checks++; if ({bus.o_STAGE_START, bus.o_STAGE, bus.o_CALC_END, bus.o_ERROR} !== 7'd0) begin failures++; $display("FAIL midrst_outputs got=%b exp=0", {bus.o_STAGE_START, bus.o_STAGE, bus.o_CALC_END, bus.o_ERROR}); end
        bus.i_BR_WRITE = 1; bus.i_CORE_WE = 1;
        #1;
        checks++; if (bus.o_RAM_ADDR !== 12'h005 || bus.o_RAM_WDATA !== 32'h0000_BEEF || bus.o_BR_BLOCKED !== 1'b0) begin failures++; $display("FAIL mux_bridge got addr=%h data=%h blk=%b exp 005 0000beef 0", bus.o_RAM_ADDR, bus.o_RAM_WDATA, bus.o_BR_BLOCKED); end
        bus.i_BR_WRITE = 0;
        #1;
        checks++; if (bus.o_RAM_WE !== 1'b0) begin failures++; $display("FAIL mux_core_dropped got=%b exp=0", bus.o_RAM_WE); end
        bus.i_CORE_WE = 0;
        tick();
        run_frame(12'd2, 1);
    endtask

    task automatic test_back_to_back();
        run_frame(12'd2048, 11);
        run_frame(12'd2, 1);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_frame_n8();
        test_bad_n(12'd6);
        test_bad_n(12'd1);
        test_timeout();
        test_mux_and_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
